// File: rtl/pe_pkg.sv
// Shared types for the ncc processing element and its log-domain window loader.
package pe_pkg;
  localparam int N_PIX = 16;
  localparam int PIX_W = 8;
  localparam int LOG_W = 33;
  localparam int IDX_W = $clog2(N_PIX);

  // bit 5 = log2 sign output, bits [4:-27] = log2 magnitude (6.27 format)
  typedef logic [LOG_W-28:-27] logval_t;

  typedef enum logic [1:0] {IDLE, FILL, LOAD_WIN, LOAD_ACC} ld_state_e;
endpackage

// File: rtl/log_window_loader_if.sv
// Pixel stream handshake into the loader.
interface log_window_loader_if;
  logic                       pixValid;
  logic                       pixReady;
  logic                       pixSel;
  logic [pe_pkg::PIX_W-1:0]   pixData;

  modport master (output pixValid, pixData, pixSel, input pixReady);
  modport slave  (input pixValid, pixData, pixSel, output pixReady);
endinterface

// File: rtl/log2.sv
// Combinational integer log2 in 5.27 fixed point, piecewise-linear between powers of two.
module log2 import pe_pkg::*; (
  input  logic [PIX_W-1:0] dataIn,
  output logic             signOut,
  output logic [31:0]      dataOut
);
  logic [4:0]       e;
  logic [PIX_W-2:0] norm;

  always_comb begin
    e = '0;
    for (int i = 1; i < PIX_W; i++)
      if (dataIn[i]) e = 5'(i);
    norm    = (PIX_W-1)'(dataIn << (5'(PIX_W-1) - e));
    // log2(0) is flagged by the sign bit with a saturated magnitude
    signOut = (dataIn == '0);
    dataOut = signOut ? '1 : {e, norm, {(28-PIX_W){1'b0}}};
  end
endmodule

// File: rtl/log_window_loader.sv
// Converts a serial pixel stream to log2 descriptor/window arrays for ncc and
// sequences the loadWinReg / loadAccSumReg pulses after each window.
module log_window_loader import pe_pkg::*; (
  input  logic                    clk,
  input  logic                    rst,
  log_window_loader_if.slave      pix,
  output logval_t [N_PIX-1:0]     descLog,
  output logval_t [N_PIX-1:0]     windowLog,
  output logic                    loadWinReg,
  output logic                    loadAccSumReg,
  output logic                    descLoaded,
  output logic [15:0]             winCount
);
  ld_state_e            state_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 isDesc_q, descLoaded_q, loadWin_q, loadAcc_q;
  logic [15:0]          winCount_q;
  logval_t [N_PIX-1:0]  shadow_q, shadow_d, desc_q, win_q, win_d;
  logic                 signOut;
  logic [31:0]          dataOut;
  logval_t              pixLog;
  logic                 accept, beatDesc, lastBeat;

  log2 u_log2 (.dataIn(pix.pixData), .signOut(signOut), .dataOut(dataOut));
  assign pixLog = {signOut, dataOut};

  // Window bursts stall in IDLE until a descriptor has been committed
  always_comb begin
    pix.pixReady = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE:    pix.pixReady = pix.pixSel | descLoaded_q;
        FILL:    pix.pixReady = 1'b1;
        default: pix.pixReady = 1'b0;
      endcase
    end
  end

  assign accept   = pix.pixValid & pix.pixReady;
  assign beatDesc = (state_q == IDLE) ? pix.pixSel : isDesc_q;
  assign lastBeat = (state_q == FILL) && (idx_q == IDX_W'(N_PIX-1));

  always_comb begin
    shadow_d = shadow_q;
    win_d    = win_q;
    if (beatDesc) shadow_d[idx_q] = pixLog;
    else          win_d[idx_q]    = pixLog;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      isDesc_q     <= 1'b0;
      descLoaded_q <= 1'b0;
      loadWin_q    <= 1'b0;
      loadAcc_q    <= 1'b0;
      winCount_q   <= '0;
      shadow_q     <= '0;
      desc_q       <= '0;
      win_q        <= '0;
    end else begin
      loadWin_q <= 1'b0;
      loadAcc_q <= 1'b0;
      if (accept) begin
        if (beatDesc) shadow_q <= shadow_d;
        else          win_q    <= win_d;
        idx_q <= idx_q + 1'b1;  // wraps to 0 after the last beat
      end
      case (state_q)
        IDLE: if (accept) begin
          isDesc_q <= pix.pixSel;
          state_q  <= FILL;
        end
        FILL: if (accept && lastBeat) begin
          if (isDesc_q) begin
            // commit includes the beat being written now
            desc_q       <= shadow_d;
            descLoaded_q <= 1'b1;
            state_q      <= IDLE;
          end else begin
            loadWin_q <= 1'b1;
            state_q   <= LOAD_WIN;
          end
        end
        LOAD_WIN: begin
          loadAcc_q <= 1'b1;
          state_q   <= LOAD_ACC;
        end
        LOAD_ACC: begin
          winCount_q <= winCount_q + 16'd1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign descLog       = desc_q;
  assign windowLog     = win_q;
  assign loadWinReg    = loadWin_q;
  assign loadAccSumReg = loadAcc_q;
  assign descLoaded    = descLoaded_q;
  assign winCount      = winCount_q;
endmodule

// File: tb/tb_log_window_loader.sv
// Bench for log_window_loader: directed bursts, a log2 vector table and random
// bursts, all checked every cycle against a burst-level reference model.
module tb_log_window_loader;
  import pe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  log_window_loader_if pif ();
  logval_t [N_PIX-1:0] descLog, windowLog;
  logic loadWinReg, loadAccSumReg, descLoaded;
  logic [15:0] winCount;

  log_window_loader dut (
    .clk(clk), .rst(rst), .pix(pif.slave),
    .descLog(descLog), .windowLog(windowLog),
    .loadWinReg(loadWinReg), .loadAccSumReg(loadAccSumReg),
    .descLoaded(descLoaded), .winCount(winCount)
  );

  int checks = 0, failures = 0;

  // reference model: beats seen in the current burst, burst type, and a
  // countdown of pulse cycles still owed after a finished window
  logval_t [N_PIX-1:0] m_desc = '0, m_win = '0, m_shadow = '0;
  int       mpos = 0, mcool = 0;
  bit       mdesc = 0, mloaded = 0, m_acc = 0;
  logic [15:0] mwc = '0;
  logic [7:0]  bdata [N_PIX];

  typedef struct { logic [7:0] pix; logval_t exp; } vec_t;
  vec_t vt [8];

  function automatic logval_t log2ref(input int x);
    int e;
    longint frac;
    if (x == 0) return {1'b1, 32'hFFFF_FFFF};
    e = 0;
    while ((1 << (e + 1)) <= x) e++;
    frac = (longint'(x - (1 << e)) << 27) >> e;
    return {1'b0, 32'((longint'(e) << 27) + frac)};
  endfunction

  task automatic chk(input string name, input logic [527:0] act, input logic [527:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // one clock: drive at negedge, compare, then advance the model at posedge
  task automatic cyc(input logic r, input logic v, input logic s, input logic [7:0] d);
    bit exp_ready;
    rst = r;
    pif.pixValid = v;
    pif.pixSel = s;
    pif.pixData = d;
    #1;
    exp_ready = !r && mcool == 0 && (mpos > 0 || s || mloaded);
    chk("pixReady", 528'(pif.pixReady), 528'(exp_ready));
    chk("loadWinReg", 528'(loadWinReg), 528'(mcool == 2));
    chk("loadAccSumReg", 528'(loadAccSumReg), 528'(mcool == 1));
    chk("descLoaded", 528'(descLoaded), 528'(mloaded));
    chk("winCount", 528'(winCount), 528'(mwc));
    chk("descLog", 528'(descLog), 528'(m_desc));
    chk("windowLog", 528'(windowLog), 528'(m_win));
    m_acc = v && exp_ready;
    @(posedge clk);
    if (r) begin
      m_desc = '0; m_win = '0; m_shadow = '0;
      mpos = 0; mcool = 0; mdesc = 0; mloaded = 0; mwc = '0;
    end else if (m_acc) begin
      if (mpos == 0) mdesc = s;
      if (mdesc) m_shadow[mpos] = log2ref(d);
      else       m_win[mpos]    = log2ref(d);
      mpos++;
      if (mpos == N_PIX) begin
        mpos = 0;
        if (mdesc) begin m_desc = m_shadow; mloaded = 1; end
        else mcool = 2;
      end
    end else if (mcool > 0) begin
      if (mcool == 1) mwc++;
      mcool--;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic send(input bit sel, input int gap_pct, input bit toggle);
    int n = 0, guard = 0;
    bit v, s;
    while (n < N_PIX && guard < 500) begin
      v = ($urandom_range(99) >= gap_pct);
      s = (n == 0 || !toggle) ? sel : 1'($urandom_range(1));
      cyc(1'b0, v, s, bdata[n]);
      if (m_acc) n++;
      guard++;
    end
    if (n < N_PIX) begin
      checks++; failures++;
      $display("FAIL burst_timeout beats=%0d required=%0d", n, N_PIX);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{8'd1,   {1'b0, 32'h0000_0000}};
    vt[1] = '{8'd2,   {1'b0, 32'h0800_0000}};
    vt[2] = '{8'd4,   {1'b0, 32'h1000_0000}};
    vt[3] = '{8'd8,   {1'b0, 32'h1800_0000}};
    vt[4] = '{8'd128, {1'b0, 32'h3800_0000}};
    vt[5] = '{8'd3,   {1'b0, 32'h0C00_0000}};
    vt[6] = '{8'd255, {1'b0, 32'h3FF0_0000}};
    vt[7] = '{8'd0,   {1'b1, 32'hFFFF_FFFF}};
    pif.pixValid = 1'b0; pif.pixSel = 1'b0; pif.pixData = '0;
    @(negedge clk);

    // reset, then a window burst with no descriptor must stall
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 1'b1, 8'h05);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 8'h07);
    idle(1);

    // descriptor 0..15, continuous
    for (int i = 0; i < N_PIX; i++) bdata[i] = 8'(i);
    send(1'b1, 0, 1'b0);
    chk("desc8_log8", 528'(descLog[8]), 528'({1'b0, 32'h1800_0000}));
    chk("desc1_log1", 528'(descLog[1]), 528'(0));
    chk("descLoaded_after", 528'(descLoaded), 528'(1));
    idle(2);

    // window 1..16, continuous
    for (int i = 0; i < N_PIX; i++) bdata[i] = 8'(i + 1);
    send(1'b0, 0, 1'b0);
    idle(4);
    chk("win3_log4", 528'(windowLog[3]), 528'({1'b0, 32'h1000_0000}));
    chk("winCount_1", 528'(winCount), 528'(1));

    // window with gaps and pixSel toggling after beat 0
    for (int i = 0; i < N_PIX; i++) bdata[i] = 8'($urandom_range(255));
    send(1'b0, 40, 1'b1);
    idle(4);

    // log2 vector table through a window burst
    for (int i = 0; i < N_PIX; i++) bdata[i] = vt[i % 8].pix;
    send(1'b0, 0, 1'b0);
    idle(3);
    for (int i = 0; i < N_PIX; i++) chk($sformatf("table_win%0d", i), 528'(windowLog[i]), 528'(vt[i % 8].exp));

    // second descriptor, all 4, straight after a window
    for (int i = 0; i < N_PIX; i++) bdata[i] = 8'd4;
    send(1'b1, 20, 1'b0);
    for (int i = 0; i < N_PIX; i++) chk($sformatf("desc4_%0d", i), 528'(descLog[i]), 528'({1'b0, 32'h1000_0000}));

    // random bursts, back to back or with short idle gaps
    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < N_PIX; i++) bdata[i] = 8'($urandom_range(255));
      send(1'($urandom_range(1)), 30, 1'b1);
      idle($urandom_range(3));
    end
    idle(3);

    // reset on beat 9 of a window burst
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 1'b0, 8'(i + 20));
    cyc(1'b1, 1'b1, 1'b0, 8'd29);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("rst_descLoaded", 528'(descLoaded), 528'(0));
    chk("rst_windowLog", 528'(windowLog), 528'(0));
    chk("rst_winCount", 528'(winCount), 528'(0));
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, 8'h11);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/log_window_loader.md
Name: log_window_loader

Overview:
- Upstream feeder for the ncc processing element.
- Accepts a serial 8-bit pixel stream with a valid/ready handshake and converts each pixel to the log domain through one shared log2 instance.
- Assembles 16-entry descriptor and window arrays in ncc's 6.27 log format.
- After each complete window, sequences ncc's loadWinReg then loadAccSumReg pulses.

Parameters:
- N_PIX, 16, pixels per descriptor or window (power of 2).
- PIX_W, 8, input pixel width.
- LOG_W, 33, log-domain word: bit 5 = log2 sign output, bits [4:-27] = log2 magnitude.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- pixValid  in  1  pixel beat valid
- pixReady  out  1  block accepts the beat this cycle
- pixData  in  PIX_W  raw pixel
- pixSel  in  1  burst type: 1 = descriptor, 0 = window; sampled on the first beat of a burst only
- descLog  out  LOG_W x N_PIX  committed descriptor, feeds ncc
- windowLog  out  LOG_W x N_PIX  window being built or just built, feeds ncc
- loadWinReg  out  1  one-cycle pulse to ncc
- loadAccSumReg  out  1  one-cycle pulse to ncc
- descLoaded  out  1  a descriptor has been committed since reset
- winCount  out  16  number of completed windows, wraps at 0xFFFF -> 0

Behaviour:
- Reset: clk and rst as in the codebase; rst is synchronous, active-high.
  - State IDLE; idx = 0; descLoaded = 0; winCount = 0.
  - descLog, windowLog and the descriptor shadow all cleared to 0.
  - loadWinReg and loadAccSumReg are 0; pixReady is 0 while rst is high.
  - rst asserted mid-burst or mid-pulse discards everything, and no further pulse is emitted.
- Beat acceptance: a beat is accepted when pixValid && pixReady at a clk edge. pixData goes combinationally through log2, so there is zero added latency. The result {signOut, dataOut} is written at that edge into entry idx.
- pixReady:
  - IDLE: 1 if pixSel = 1 or descLoaded = 1. A window burst is stalled until a descriptor exists.
  - FILL: 1.
  - LOAD_WIN, LOAD_ACC: 0.
- States:
  - IDLE -> FILL on an accepted beat. The burst type is latched from pixSel and idx becomes 1.
    - A 1-pixel burst is impossible: N_PIX >= 2.
  - FILL: each accepted beat increments idx. pixSel on non-first beats is ignored.
    - Gaps (pixValid = 0) are allowed indefinitely.
  - FILL, beat with idx = N_PIX-1:
    - Descriptor burst -> IDLE. The next cycle the shadow, including this last entry, is copied into descLog atomically and descLoaded = 1.
    - Window burst -> LOAD_WIN.
  - idx wraps to 0 at the end of every burst.
  - LOAD_WIN: loadWinReg = 1 for exactly 1 cycle -> LOAD_ACC.
  - LOAD_ACC: loadAccSumReg = 1 for 1 cycle, and winCount increments -> IDLE.
- Timing: if the last window beat is accepted at edge t:
  - loadWinReg is high during cycle t+1.
  - loadAccSumReg is high during cycle t+2.
  - pixReady is back high from cycle t+3.
- Output stability:
  - windowLog entries are written directly and are stable through LOAD_WIN and LOAD_ACC.
  - windowLog may change once a new burst starts; ncc has already registered it.
  - descLog changes only on the commit cycle. A descriptor burst never disturbs an in-use descriptor.
- No simultaneous-event conflicts: pulses and acceptance are mutually exclusive by state.

Decomposition:
- Package pe_pkg:
  - typedef logic [5:-27] logval_t
  - localparams N_PIX = 16, PIX_W = 8
  - enum of loader states {IDLE, FILL, LOAD_WIN, LOAD_ACC}
  - ncc uses the same package.
- Sub-module: one instance of the existing log2, shared by both burst types. No new sub-module.

Test Plan:
- Reset, then a window burst with no descriptor:
  - pixReady = 0 with pixSel = 0; no pulses.
  - winCount = 0, descLoaded = 0.
- Descriptor burst, pixels 0..15, continuous valid:
  - descLog stays 0 until the cycle after beat 15, then updates.
  - descLog[8] = {1'b0, 32'h18000000} (log2 8 = 3.0), descLog[1] magnitude = 0, descLoaded = 1.
  - No loadWinReg or loadAccSumReg pulse.
- Window burst, pixels 1..16, after the descriptor:
  - windowLog[3] = {0, 32'h10000000}.
  - Last beat accepted at t; loadWinReg high only in cycle t+1 and loadAccSumReg only in t+2.
  - pixReady = 0 in t+1 and t+2; winCount = 1.
- Window burst with pixValid gaps and pixSel toggling after beat 0:
  - Treated as a window; same pulse timing relative to the last beat.
  - Descriptor unchanged.
- Second descriptor burst, all pixels = 4, entered after a window:
  - descLog keeps the old values for all 16 beats, then every entry = {0, 32'h10000000} in one cycle.
- rst at beat 9 of a window burst:
  - Next cycle everything is cleared and no pulses occur.
  - A following window burst stalls because descLoaded = 0.
